// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential BCD subtractor.
//   state_t     controller state encoding (CMPL only exists when
//               BCD_SUB_SIGN_MAG_EN is defined)
//   bcd_digit_t one packed BCD digit
//   BCD_MAX     largest legal BCD digit value
//   BCD_CORR    correction added to a digit that borrowed
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SUB   = 3'd2,
`ifdef BCD_SUB_SIGN_MAG_EN
    ST_CMPL  = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bcd_sub_seq_if.sv
// bcd_sub_seq_if: host <-> subtractor handshake bundle.
//   start   host request (sampled by the block only while idle)
//   a, b    packed BCD minuend / subtrahend, digit 0 in [3:0]
//   busy    block is working
//   done    one-cycle result-valid pulse
//   diff    packed BCD result
//   borrow  final borrow out of the top digit
//   neg     result sign
//   invalid an operand digit exceeded 9
// master = host side, slave = subtractor side.
interface bcd_sub_seq_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, neg, invalid
  );
endinterface

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational one-digit BCD subtract/correct slice.
//   a, b   input digits
//   bin    borrow in
//   nibble corrected result digit
//   bout   borrow out
// The 2:1 correction mux picks the +10 corrected nibble whenever the
// raw 5-bit difference went negative, so its select is the borrow out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t nibble,
  output logic       bout
);

  logic [4:0] raw_s;
  bcd_digit_t corr_s;

  // Raw difference, borrow extraction and correction mux.
  always_comb begin
    raw_s  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    bout   = raw_s[4];
    corr_s = raw_s[3:0] + BCD_CORR;
    if (bout) begin
      nibble = corr_s;
    end else begin
      nibble = raw_s[3:0];
    end
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: sequential multi-digit BCD subtractor controller.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_sub_seq_if.slave (start/a/b in; busy/done/diff/borrow/
//          neg/invalid out)
// Operands are latched on an accepted start, checked for illegal digits,
// then subtracted one digit per cycle through a single bcd_digit_sub.
// Optional feature macro: BCD_SUB_SIGN_MAG_EN -- when defined, a negative
// result is converted to sign/magnitude by a second pass (0 - diff).
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  bcd_sub_seq_if.slave  bus
);

  localparam int             IW       = $clog2(DIGITS) + 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

  state_t              state_r, state_next_s;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] a_r, b_r, diff_r;
  logic                bin_r, borrow_r, neg_r, invalid_r, done_r, busy_r;
  logic                bad_s, last_s;
  bcd_digit_t          sa_s, sb_s, nib_s;
  logic                bout_s;

  assign last_s = (idx_r == LAST_IDX);

  // Flag any latched operand digit above 9.
  always_comb begin
    bad_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((a_r[4*k +: 4] > BCD_MAX) || (b_r[4*k +: 4] > BCD_MAX)) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // Slice operands: a_i - b_i during SUB, 0 - diff_i during CMPL.
  always_comb begin
    if (state_r == ST_SUB) begin
      sa_s = a_r[{idx_r, 2'b00} +: 4];
      sb_s = b_r[{idx_r, 2'b00} +: 4];
    end else begin
      sa_s = 4'd0;
      sb_s = diff_r[{idx_r, 2'b00} +: 4];
    end
  end

  bcd_digit_sub u_slice (
    .a      (sa_s),
    .b      (sb_s),
    .bin    (bin_r),
    .nibble (nib_s),
    .bout   (bout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bad_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SUB;
        end
      end
      ST_SUB: begin
        if (last_s) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          state_next_s = bout_s ? ST_CMPL : ST_DONE;
`else
          state_next_s = ST_DONE;
`endif
        end else begin
          state_next_s = ST_SUB;
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      ST_CMPL: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CMPL;
        end
      end
`endif
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs. done/busy are delayed views of the
  // state so that busy drops on the same edge as the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      diff_r    <= '0;
      bin_r     <= 1'b0;
      borrow_r  <= 1'b0;
      neg_r     <= 1'b0;
      invalid_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DONE);
      busy_r <= (state_next_s != ST_IDLE) || (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        ST_CHECK: begin
          idx_r <= '0;
          bin_r <= 1'b0;
          if (bad_s) begin
            invalid_r <= 1'b1;
            diff_r    <= '0;
            borrow_r  <= 1'b0;
            neg_r     <= 1'b0;
          end else begin
            invalid_r <= 1'b0;
          end
        end
        ST_SUB: begin
          diff_r[{idx_r, 2'b00} +: 4] <= nib_s;
          if (last_s) begin
            idx_r    <= '0;
            bin_r    <= 1'b0;
            borrow_r <= bout_s;
            neg_r    <= bout_s;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            bin_r <= bout_s;
          end
        end
`ifdef BCD_SUB_SIGN_MAG_EN
        // Magnitude pass; sign and borrow from SUB are kept.
        ST_CMPL: begin
          diff_r[{idx_r, 2'b00} +: 4] <= nib_s;
          if (last_s) begin
            idx_r <= '0;
            bin_r <= 1'b0;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            bin_r <= bout_s;
          end
        end
`endif
        ST_DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.diff    = diff_r;
  assign bus.borrow  = borrow_r;
  assign bus.neg     = neg_r;
  assign bus.invalid = invalid_r;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: directed self-checking bench for bcd_sub_seq (DIGITS=4).
// Edge numbering: E0 is the posedge that accepts start; k counts posedges
// after E0 and outputs are sampled on the following negedge.
module tb_bcd_sub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_sub_seq_if #(.DIGITS(4)) ifc ();

  bcd_sub_seq #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

`ifdef BCD_SUB_SIGN_MAG_EN
  localparam int NEG_LAT = 10;
  localparam logic [15:0] NEG_DIFF = 16'h0001;
`else
  localparam int NEG_LAT = 6;
  localparam logic [15:0] NEG_DIFF = 16'h9999;
`endif

  // Drive start for one cycle; returns at the negedge after E0 (k=0).
  task automatic start_op(input logic [15:0] ia, input logic [15:0] ib);
    @(negedge clk);
    ifc.a = ia;
    ifc.b = ib;
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Wait (bounded) for done; k returns the edge index, -1 on timeout.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (ifc.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) k = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.a = 16'h0000;
    ifc.b = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.busy, ifc.done, ifc.borrow, ifc.neg, ifc.invalid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {ifc.busy, ifc.done, ifc.borrow, ifc.neg, ifc.invalid});
    end
    checks++;
    if (ifc.diff !== 16'h0000) begin
      errors++;
      $display("FAIL reset_diff got %h want 0000", ifc.diff);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int k;
    start_op(16'h5432, 16'h1234);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise got %b want 1", ifc.busy);
    end
    wait_done(0, k);
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL basic_latency got %0d want 6", k);
    end
    checks++;
    if ({ifc.diff, ifc.borrow, ifc.neg, ifc.invalid} !== {16'h4198, 3'b000}) begin
      errors++;
      $display("FAIL basic_result got %h/%b%b%b want 4198/000",
               ifc.diff, ifc.borrow, ifc.neg, ifc.invalid);
    end
    @(negedge clk);
    checks++;
    if ({ifc.done, ifc.busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", ifc.done, ifc.busy);
    end
  endtask

  task automatic test_ripple;
    int k;
    start_op(16'h1000, 16'h0001);
    wait_done(0, k);
    checks++;
    if (k != 6 || ifc.diff !== 16'h0999 || ifc.borrow !== 1'b0) begin
      errors++;
      $display("FAIL ripple got k=%0d diff=%h borrow=%b want k=6 diff=0999 borrow=0",
               k, ifc.diff, ifc.borrow);
    end
  endtask

  task automatic test_negative;
    int k;
    start_op(16'h0001, 16'h0002);
    wait_done(0, k);
    checks++;
    if (k != NEG_LAT) begin
      errors++;
      $display("FAIL neg_latency got %0d want %0d", k, NEG_LAT);
    end
    checks++;
    if (ifc.diff !== NEG_DIFF || ifc.borrow !== 1'b1 || ifc.neg !== 1'b1) begin
      errors++;
      $display("FAIL neg_result got diff=%h borrow=%b neg=%b want diff=%h borrow=1 neg=1",
               ifc.diff, ifc.borrow, ifc.neg, NEG_DIFF);
    end
  endtask

  task automatic test_invalid;
    int k;
    start_op(16'h00A0, 16'h0000);
    wait_done(0, k);
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL invalid_latency got %0d want 2", k);
    end
    checks++;
    if ({ifc.invalid, ifc.diff, ifc.borrow, ifc.neg} !== {1'b1, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL invalid_result got inv=%b diff=%h borrow=%b neg=%b want 1 0000 0 0",
               ifc.invalid, ifc.diff, ifc.borrow, ifc.neg);
    end
  endtask

  task automatic test_ignore_start;
    int k;
    int extra;
    start_op(16'h5432, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    ifc.a = 16'h9999;
    ifc.b = 16'h0000;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(3, k);
    checks++;
    if (k != 6 || ifc.diff !== 16'h4198 || ifc.invalid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got k=%0d diff=%h inv=%b want k=6 diff=4198 inv=0",
               k, ifc.diff, ifc.invalid);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_no_rerun got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    start_op(16'h9876, 16'h1234);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.busy, ifc.done, ifc.borrow, ifc.neg, ifc.invalid, ifc.diff} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b diff=%h borrow=%b neg=%b inv=%b want all 0",
               ifc.busy, ifc.done, ifc.diff, ifc.borrow, ifc.neg, ifc.invalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.diff !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_idle got busy=%b diff=%h want 0 0000", ifc.busy, ifc.diff);
    end
    start_op(16'h2000, 16'h0001);
    wait_done(0, k);
    checks++;
    if (k != 6 || ifc.diff !== 16'h1999) begin
      errors++;
      $display("FAIL midreset_next got k=%0d diff=%h want k=6 diff=1999", k, ifc.diff);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int kd [3];
    logic [15:0] dd [3];
    int exp_k [3];
    logic [15:0] exp_d [3];
    exp_k[0] = 6;  exp_k[1] = 13; exp_k[2] = 20;
    exp_d[0] = 16'h4198; exp_d[1] = 16'h0001; exp_d[2] = 16'h7000;
    n = 0;
    @(negedge clk);
    ifc.a = 16'h5432;
    ifc.b = 16'h1234;
    ifc.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        if (n < 3) begin
          kd[n] = k;
          dd[n] = ifc.diff;
        end
        n++;
      end
      if (k == 1) begin
        ifc.a = 16'h0100;
        ifc.b = 16'h0099;
      end
      if (k == 8) begin
        ifc.a = 16'h7777;
        ifc.b = 16'h0777;
      end
      if (k == 20) ifc.start = 1'b0;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d done pulses want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        checks++;
        if (kd[i] != exp_k[i] || dd[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL b2b_op%0d got k=%0d diff=%h want k=%0d diff=%h",
                   i, kd[i], dd[i], exp_k[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ripple;
    test_negative;
    test_invalid;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
